wb_arbiter: RTL and testbench

Two-master to one-slave Wishbone B4 classic arbiter. It lets the SPI bridge (master 0) and a second bridge, such as UART or debug (master 1), share the single peripheral bus inside top, which carries the charlie7x5 driver and other slaves. Arbitration is round-robin with registered grant. A bus-timeout counter terminates hung cycles with err so a missing slave cannot lock the bus.

---
 rtl/wb_arbiter.sv | 129 ++++++++++++
 tb/tb_wb_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Two-master to one-slave Wishbone B4 classic arbiter with round-robin grant
// and a bus-timeout abort so a missing slave cannot lock the shared bus.
module wb_arbiter #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,

    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,

    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_err_i
);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1, StAbort} state_e;

    state_e       state_q;
    logic         last_q;
    logic [7:0]   tcnt_q;

    logic                  own0, own1, own;
    logic                  sel_cyc, sel_stb, sel_we;
    logic [ADDR_WIDTH-1:0] sel_adr;
    logic [DATA_WIDTH-1:0] sel_dat;
    logic                  waiting, timeout_hit, abort_cyc;

    always_comb begin
        own0    = (state_q == StOwn0);
        own1    = (state_q == StOwn1);
        own     = own0 | own1;

        sel_cyc = own1 ? m1_cyc_i : m0_cyc_i;
        sel_stb = own1 ? m1_stb_i : m0_stb_i;
        sel_we  = own1 ? m1_we_i  : m0_we_i;
        sel_adr = own1 ? m1_adr_i : m0_adr_i;
        sel_dat = own1 ? m1_dat_i : m0_dat_i;

        s_cyc_o = own & sel_cyc;
        // stb without cyc never reaches the slave
        s_stb_o = own & sel_cyc & sel_stb;
        s_we_o  = own & sel_we;
        s_adr_o = own ? sel_adr : '0;
        s_dat_o = own ? sel_dat : '0;

        waiting     = s_stb_o & ~s_ack_i & ~s_err_i;
        timeout_hit = waiting && (tcnt_q == 8'(TIMEOUT));

        m0_ack_o = own0 & s_ack_i;
        m0_err_o = own0 & (s_err_i | timeout_hit);
        m0_dat_o = own0 ? s_dat_i : '0;
        m1_ack_o = own1 & s_ack_i;
        m1_err_o = own1 & (s_err_i | timeout_hit);
        m1_dat_o = own1 ? s_dat_i : '0;

        // last_q names the aborted master while in StAbort
        abort_cyc = last_q ? m1_cyc_i : m0_cyc_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            tcnt_q  <= 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tcnt_q <= 8'd0;
                    if (m0_cyc_i && m1_cyc_i) begin
                        state_q <= last_q ? StOwn0 : StOwn1;
                    end else if (m0_cyc_i) begin
                        state_q <= StOwn0;
                    end else if (m1_cyc_i) begin
                        state_q <= StOwn1;
                    end
                end
                StOwn0, StOwn1: begin
                    if (!sel_cyc) begin
                        state_q <= StIdle;
                        last_q  <= own1;
                        tcnt_q  <= 8'd0;
                    end else if (timeout_hit) begin
                        state_q <= StAbort;
                        last_q  <= own1;
                        tcnt_q  <= 8'd0;
                    end else if (waiting) begin
                        tcnt_q <= tcnt_q + 8'd1;
                    end else begin
                        tcnt_q <= 8'd0;
                    end
                end
                StAbort: begin
                    tcnt_q <= 8'd0;
                    if (!abort_cyc) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tcnt_q  <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized masters and slave,
// every output checked each cycle against a behavioural ownership model.
module tb_wb_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]    m_cyc, m_stb, m_we;
    logic [AW-1:0] m_adr [2];
    logic [DW-1:0] m_dat [2];
    logic [DW-1:0] m0_dat_o, m1_dat_o;
    logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o, s_dat_i;
    logic          s_ack_i, s_err_i;

    wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]),
        .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]),
        .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, who is being aborted, who was served last
    int md_owner = -1;
    bit md_abort = 1'b0;
    int md_who   = 0;
    int md_last  = 1;
    int md_wait  = 0;

    int           ack_log [$];
    int           cnt_ack [2];
    int           cnt_err [2];
    logic [1:0]   got_ack, got_err, smp_ack;
    logic         smp_scyc, smp_err0;
    logic [DW-1:0] last_m1_dat;

    // Stimulus agents
    bit en [2];
    bit act [2];
    int beats [2];
    int req_pct [2], blo [2], bhi [2], stb_pct [2];
    int abandon_pct, ack_pct, err_pct;
    bit fix_en;
    logic [DW-1:0] fix_dat;

    task automatic step();
        int x;
        bit tmo;
        logic [1:0] e_ack, e_err;
        logic [DW-1:0] e_d0, e_d1;
        #1;
        e_ack = '0;
        e_err = '0;
        tmo   = 1'b0;
        if (md_owner >= 0) begin
            x    = md_owner;
            tmo  = (md_wait == TO) && m_cyc[x] && m_stb[x] && !s_ack_i && !s_err_i;
            e_ack[x] = s_ack_i;
            e_err[x] = s_err_i | tmo;
            e_d0 = (x == 0) ? s_dat_i : '0;
            e_d1 = (x == 1) ? s_dat_i : '0;
            check_eq("s_cyc", 32'(s_cyc_o), 32'(m_cyc[x]));
            check_eq("s_stb", 32'(s_stb_o), 32'(m_cyc[x] & m_stb[x]));
            check_eq("s_we", 32'(s_we_o), 32'(m_we[x]));
            check_eq("s_adr", 32'(s_adr_o), 32'(m_adr[x]));
            check_eq("s_dat", 32'(s_dat_o), 32'(m_dat[x]));
            check_eq("m0_dat", 32'(m0_dat_o), 32'(e_d0));
            check_eq("m1_dat", 32'(m1_dat_o), 32'(e_d1));
        end else begin
            check_eq("s_cyc_idle", 32'(s_cyc_o), 32'd0);
            check_eq("s_stb_idle", 32'(s_stb_o), 32'd0);
            check_eq("s_we_idle", 32'(s_we_o), 32'd0);
        end
        check_eq("m0_ack", 32'(m0_ack_o), 32'(e_ack[0]));
        check_eq("m0_err", 32'(m0_err_o), 32'(e_err[0]));
        check_eq("m1_ack", 32'(m1_ack_o), 32'(e_ack[1]));
        check_eq("m1_err", 32'(m1_err_o), 32'(e_err[1]));

        got_ack  = {m1_ack_o & m_cyc[1] & m_stb[1], m0_ack_o & m_cyc[0] & m_stb[0]};
        got_err  = {m1_err_o & m_cyc[1] & m_stb[1], m0_err_o & m_cyc[0] & m_stb[0]};
        smp_ack  = {m1_ack_o, m0_ack_o};
        smp_scyc = s_cyc_o;
        smp_err0 = m0_err_o;
        if (got_ack[0]) ack_log.push_back(0);
        if (got_ack[1]) begin
            ack_log.push_back(1);
            last_m1_dat = m1_dat_o;
        end
        cnt_ack[0] += int'(m0_ack_o);
        cnt_ack[1] += int'(m1_ack_o);
        cnt_err[0] += int'(m0_err_o);
        cnt_err[1] += int'(m1_err_o);

        @(posedge clk);
        if (rst) begin
            md_owner = -1; md_abort = 1'b0; md_last = 1; md_wait = 0;
        end else if (md_abort) begin
            if (!m_cyc[md_who]) md_abort = 1'b0;
        end else if (md_owner < 0) begin
            if (m_cyc == 2'b11) md_owner = 1 - md_last;
            else if (m_cyc[0])  md_owner = 0;
            else if (m_cyc[1])  md_owner = 1;
            md_wait = 0;
        end else begin
            x = md_owner;
            if (!m_cyc[x]) begin
                md_last = x; md_owner = -1; md_wait = 0;
            end else if (tmo) begin
                md_last = x; md_who = x; md_abort = 1'b1; md_owner = -1; md_wait = 0;
            end else if (m_stb[x] && !s_ack_i && !s_err_i) begin
                md_wait++;
            end else begin
                md_wait = 0;
            end
        end
        #1;
    endtask

    task automatic new_beat(input int i);
        m_stb[i] = ($urandom_range(0, 99) < stb_pct[i]);
        m_we[i]  = 1'($urandom);
        m_adr[i] = AW'($urandom);
        m_dat[i] = DW'($urandom);
    endtask

    task automatic drive_agents();
        for (int i = 0; i < 2; i++) begin
            if (!en[i]) begin
                act[i] = 1'b0; m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
            end else if (act[i]) begin
                if (got_err[i] || $urandom_range(0, 99) < abandon_pct) begin
                    act[i] = 1'b0; m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
                end else if (got_ack[i]) begin
                    beats[i]--;
                    if (beats[i] == 0) begin
                        act[i] = 1'b0; m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
                    end else begin
                        new_beat(i);
                    end
                end else if (!m_stb[i]) begin
                    m_stb[i] = ($urandom_range(0, 99) < stb_pct[i]);
                end
            end else if ($urandom_range(0, 99) < req_pct[i]) begin
                act[i]   = 1'b1;
                beats[i] = $urandom_range(blo[i], bhi[i]);
                m_cyc[i] = 1'b1;
                new_beat(i);
            end else begin
                m_cyc[i] = 1'b0;
                m_stb[i] = ($urandom_range(0, 9) == 0);
            end
        end
        s_ack_i = ($urandom_range(0, 99) < ack_pct);
        s_err_i = ($urandom_range(0, 99) < err_pct);
        s_dat_i = fix_en ? fix_dat : DW'($urandom);
    endtask

    task automatic quiet();
        m_cyc = '0; m_stb = '0; m_we = '0;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0; act[i] = 1'b0;
            cnt_ack[i] = 0; cnt_err[i] = 0;
        end
        got_ack = '0; got_err = '0;
        ack_log.delete();
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b1;
        step();
        rst = 1'b0;
        quiet();
    endtask

    task automatic setup_agent(input int i, input int rq, input int lo, input int hi, input int sp);
        en[i] = 1'b1; req_pct[i] = rq; blo[i] = lo; bhi[i] = hi; stb_pct[i] = sp;
    endtask

    initial begin
        int err_at;
        for (int i = 0; i < 2; i++) begin
            m_adr[i] = '0; m_dat[i] = '0;
        end
        abandon_pct = 0; ack_pct = 100; err_pct = 0; fix_en = 1'b0; fix_dat = '0;
        last_m1_dat = '0;
        quiet();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and single master-0 write
        step();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
        m_adr[0] = 4'd3; m_dat[0] = 8'hA5;
        step();
        check_eq("wr_grant_latency", 32'(smp_scyc), 32'd0);
        step();
        check_eq("wr_granted", 32'(smp_scyc), 32'd1);
        s_ack_i = 1'b1;
        step();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack_i = 1'b0;
        step();
        step();
        check_eq("wr_m0_acks", 32'(cnt_ack[0]), 32'd1);
        check_eq("wr_m1_acks", 32'(cnt_ack[1]), 32'd0);

        // Tie after reset then round-robin fairness over 8 transactions
        do_reset();
        ack_pct = 100; err_pct = 0; fix_en = 1'b1; fix_dat = 8'h3C;
        setup_agent(0, 100, 1, 1, 100);
        setup_agent(1, 100, 1, 1, 100);
        repeat (30) begin
            drive_agents();
            step();
        end
        check_eq("rr_count", 32'(ack_log.size() >= 8), 32'd1);
        for (int i = 0; i < 8 && i < ack_log.size(); i++) begin
            check_eq($sformatf("rr_order[%0d]", i), 32'(ack_log[i]), 32'(i % 2));
        end
        check_eq("rr_m1_rdata", 32'(last_m1_dat), 32'h3C);

        // Burst hold: master 1 keeps four beats, master 0 waits
        do_reset();
        ack_pct = 100; fix_en = 1'b0;
        setup_agent(1, 100, 4, 4, 100);
        drive_agents();
        step();
        setup_agent(0, 100, 1, 1, 100);
        repeat (14) begin
            drive_agents();
            step();
        end
        check_eq("burst_count", 32'(ack_log.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < ack_log.size(); i++) begin
            check_eq($sformatf("burst_order[%0d]", i), 32'(ack_log[i]), 32'(i < 4 ? 1 : 0));
        end

        // Timeout with no slave response, then held cyc in abort
        do_reset();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        err_at = -1;
        for (int k = 0; k < 9; k++) begin
            step();
            if (smp_err0 && err_at < 0) err_at = k;
        end
        check_eq("to_err_cycle", 32'(err_at), 32'd5);
        check_eq("to_err_count", 32'(cnt_err[0]), 32'd1);
        check_eq("to_abort_idle", 32'(smp_scyc), 32'd0);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        step();
        step();

        // Ack on the cycle the counter reaches the limit wins over the timeout
        do_reset();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) s_ack_i = 1'b1;
            step();
        end
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack_i = 1'b0;
        step();
        check_eq("late_ack_count", 32'(cnt_ack[0]), 32'd1);
        check_eq("late_ack_no_err", 32'(cnt_err[0]), 32'd0);

        // Reset while master 1 owns the bus with stb pending
        do_reset();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        step();
        step();
        step();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check_eq("rst_bus_idle", 32'(smp_scyc), 32'd0);
        s_ack_i = 1'b1;
        step();
        check_eq("rst_tie_m0", 32'(smp_ack[0]), 32'd1);
        check_eq("rst_tie_not_m1", 32'(smp_ack[1]), 32'd0);
        check_eq("rst_m1_no_ack", 32'(cnt_ack[1]), 32'd0);

        // Randomized traffic across slave behaviours
        for (int ph = 0; ph < 4; ph++) begin
            do_reset();
            ack_pct     = (ph == 3) ? 0 : 90 - ph * 35;
            err_pct     = (ph == 1) ? 5 : 1;
            abandon_pct = 2;
            fix_en      = 1'b0;
            for (int i = 0; i < 2; i++) begin
                setup_agent(i, $urandom_range(40, 90), 1, 4, $urandom_range(60, 100));
            end
            for (int c = 0; c < 500; c++) begin
                drive_agents();
                rst = ($urandom_range(0, 299) == 0);
                step();
            end
            rst = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
